// File: rtl/bpm_ctrl_pkg.sv
// bpm_ctrl_pkg: shared state encoding, widths and default tick limits
// for the BPM measurement sequencer.
package bpm_ctrl_pkg;
    localparam int INT_W = 6;
    localparam int BPM_W = 8;
    localparam int TMO_W = 7;
    localparam int MIN_TICKS_DEF = 8;
    localparam int MAX_TICKS_DEF = 60;
    localparam int TIMEOUT_TICKS_DEF = 75;
    typedef enum logic [2:0] {IDLE, ARM, CHECK, DIV, RELEASE} state_e;
endpackage

// File: rtl/bpm_avg4.sv
// bpm_avg4: 4-entry moving average of accepted BPM results with one-cycle valid delay.
// Only compiled when BPM_MEASURE_CTRL_AVG_EN is defined.
`ifdef BPM_MEASURE_CTRL_AVG_EN
module bpm_avg4
    import bpm_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [BPM_W-1:0] bpm_i,
    output logic [BPM_W-1:0] avg_o,
    output logic             valid_o
);
    logic [BPM_W-1:0] win_q [4];
    logic [BPM_W-1:0] avg_q;
    logic [BPM_W+1:0] sum;
    logic             first_q, load_q, valid_q;

    assign sum = {2'b0, win_q[0]} + {2'b0, win_q[1]} + {2'b0, win_q[2]} + {2'b0, win_q[3]};
    assign avg_o = avg_q;
    assign valid_o = valid_q;

    // The first result after a restart fills the whole window so it is not averaged with stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '{default: '0};
            avg_q   <= '0;
            first_q <= 1'b1;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            first_q <= clear_i ? 1'b1 : (load_i ? 1'b0 : first_q);
            load_q  <= load_i;
            valid_q <= load_q;
            if (load_i) begin
                win_q[0] <= bpm_i;
                win_q[1] <= first_q ? bpm_i : win_q[0];
                win_q[2] <= first_q ? bpm_i : win_q[1];
                win_q[3] <= first_q ? bpm_i : win_q[2];
            end
            if (load_q) avg_q <= sum[BPM_W+1:2];
        end
    end
endmodule
`endif

// File: rtl/bpm_measure_ctrl.sv
// bpm_measure_ctrl: arms the beat-interval counter, range-checks intervals, drives the BPM divider.
// Define BPM_MEASURE_CTRL_AVG_EN to publish a 4-entry moving average instead of the raw result.
module bpm_measure_ctrl
    import bpm_ctrl_pkg::*;
#(
    parameter int MIN_TICKS     = MIN_TICKS_DEF,
    parameter int MAX_TICKS     = MAX_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_25hz,
    input  logic             ti_valid,
    input  logic [INT_W-1:0] ti_count,
    output logic             ti_en,
    output logic             ti_done,
    output logic             div_req,
    output logic [INT_W-1:0] div_interval,
    input  logic             div_ack,
    input  logic [BPM_W-1:0] div_bpm,
    output logic [BPM_W-1:0] bpm_out,
    output logic             bpm_valid,
    output logic             reject,
    output logic             no_signal,
    output logic             busy
);
    localparam logic [INT_W-1:0] MIN_C = INT_W'(MIN_TICKS);
    localparam logic [INT_W-1:0] MAX_C = INT_W'(MAX_TICKS);
    localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TIMEOUT_TICKS);

    state_e           state_q, state_d;
    logic             discard_q, discard_d, div_req_q, div_req_d, no_signal_q, no_signal_d;
    logic             ti_en_q, ti_done_q, reject_q, reject_d, busy_q, acc;
    logic [TMO_W-1:0] tmo_q, tmo_d, tick_inc;
    logic [INT_W-1:0] div_interval_q, div_interval_d;

    assign tick_inc = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        discard_d      = discard_q;
        tmo_d          = tmo_q;
        div_req_d      = div_req_q;
        div_interval_d = div_interval_q;
        no_signal_d    = no_signal_q;
        reject_d       = 1'b0;
        acc            = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (start && !stop) begin
                    state_d   = ARM;
                    discard_d = 1'b1;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    if (tick_25hz) begin
                        tmo_d = tick_inc;
                        if (tick_inc == TMO_C) begin
                            no_signal_d = 1'b1;
                            discard_d   = 1'b1;
                        end
                    end
                    if (ti_valid) begin
                        state_d = CHECK;
                        tmo_d   = '0;
                    end
                end
            end
            CHECK: begin
                if (stop) begin
                    state_d = RELEASE;
                end else if (discard_q || ti_count < MIN_C || ti_count > MAX_C) begin
                    reject_d  = 1'b1;
                    discard_d = 1'b0;
                    state_d   = RELEASE;
                end else begin
                    div_interval_d = ti_count;
                    div_req_d      = 1'b1;
                    state_d        = DIV;
                end
            end
            DIV: begin
                if (div_ack) begin
                    div_req_d   = 1'b0;
                    no_signal_d = 1'b0;
                    acc         = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                if (!ti_valid) state_d = (stop || !start) ? IDLE : ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Level outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            discard_q      <= 1'b1;
            tmo_q          <= '0;
            div_req_q      <= 1'b0;
            div_interval_q <= '0;
            no_signal_q    <= 1'b0;
            reject_q       <= 1'b0;
            ti_en_q        <= 1'b0;
            ti_done_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            discard_q      <= discard_d;
            tmo_q          <= tmo_d;
            div_req_q      <= div_req_d;
            div_interval_q <= div_interval_d;
            no_signal_q    <= no_signal_d;
            reject_q       <= reject_d;
            ti_en_q        <= state_d == ARM;
            ti_done_q      <= state_d == RELEASE && state_q != RELEASE;
            busy_q         <= state_d != IDLE;
        end
    end

    assign ti_en        = ti_en_q;
    assign ti_done      = ti_done_q;
    assign div_req      = div_req_q;
    assign div_interval = div_interval_q;
    assign reject       = reject_q;
    assign no_signal    = no_signal_q;
    assign busy         = busy_q;

`ifdef BPM_MEASURE_CTRL_AVG_EN
    bpm_avg4 u_avg (
        .clk    (clk),
        .rst    (rst),
        .clear_i(state_q == IDLE),
        .load_i (acc),
        .bpm_i  (div_bpm),
        .avg_o  (bpm_out),
        .valid_o(bpm_valid)
    );
`else
    logic [BPM_W-1:0] bpm_q;
    logic             bpm_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
        end else begin
            bpm_q       <= acc ? div_bpm : bpm_q;
            bpm_valid_q <= acc;
        end
    end

    assign bpm_out   = bpm_q;
    assign bpm_valid = bpm_valid_q;
`endif
endmodule

// File: tb/tb_bpm_measure_ctrl.sv
// tb_bpm_measure_ctrl: directed and randomized interval transactions checked against a
// transaction-level model of accept/reject, published BPM and the no-signal flag.
module tb_bpm_measure_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, stop, tick_25hz, ti_valid, div_ack;
    logic [5:0] ti_count, div_interval;
    logic [7:0] div_bpm, bpm_out;
    logic       ti_en, ti_done, div_req, bpm_valid, reject, no_signal, busy;

    int         n_vec = 0, n_err = 0;
    logic [7:0] m_bpm = 8'd0;
    bit         m_ns = 1'b0, m_discard = 1'b1, m_first = 1'b1;
    int         win[$];

    always #5 clk = ~clk;

    bpm_measure_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .tick_25hz(tick_25hz),
        .ti_valid(ti_valid), .ti_count(ti_count), .ti_en(ti_en), .ti_done(ti_done),
        .div_req(div_req), .div_interval(div_interval), .div_ack(div_ack), .div_bpm(div_bpm),
        .bpm_out(bpm_out), .bpm_valid(bpm_valid), .reject(reject), .no_signal(no_signal),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_accept(input logic [7:0] b);
`ifdef BPM_MEASURE_CTRL_AVG_EN
        int s;
        s = 0;
        if (m_first) win = '{int'(b), int'(b), int'(b), int'(b));
        else begin
            win.push_back(int'(b));
            void'(win.pop_front());
        end
        foreach (win[i]) s += win[i];
        m_bpm   = 8'(s / 4);
        m_first = 1'b0;
`else
        m_bpm = b;
`endif
        m_ns = 1'b0;
    endfunction

    // Presents one interval from ARM, plays the counter and divider sides, and checks the outcome.
    task automatic run_interval(input int cnt, input logic [7:0] bpm, input int ack_dly,
                                input bit stop_div, input string tag);
        int cyc, req_lat, rej_n, done_n, val_n, req_n, bad_int, early, done_at;
        bit exp_rej, fin;
        cyc = 0; req_lat = -1; rej_n = 0; done_n = 0; val_n = 0; req_n = 0;
        bad_int = 0; early = 0; done_at = -1; fin = 1'b0;
        exp_rej = m_discard || cnt < 8 || cnt > 60;
        ti_count = 6'(cnt);
        ti_valid = 1'b1;
        while (cyc < 100 && !fin) begin
            step();
            cyc++;
            div_ack = 1'b0;
            if (reject) rej_n++;
            if (ti_done) begin done_n++; done_at = cyc; end
            if (bpm_valid) val_n++;
            if (ti_en && ti_valid) early++;
            if (div_req) begin
                req_n++;
                if (req_lat < 0) req_lat = cyc;
                if (div_interval !== 6'(cnt)) bad_int++;
                if (stop_div) stop = 1'b1;
                if (req_n == ack_dly) begin div_ack = 1'b1; div_bpm = bpm; end
            end
            if (done_at > 0 && cyc == done_at + 1) ti_valid = 1'b0;
            if (!ti_valid && (ti_en || !busy)) fin = 1'b1;
        end
        div_ack = 1'b0;
        if (!exp_rej) model_accept(bpm);
        m_discard = 1'b0;
        if (stop_div) m_first = 1'b1;
        chk({tag, " finished"}, 32'(fin), 1);
        chk({tag, " reject"}, rej_n, exp_rej ? 1 : 0);
        chk({tag, " ti_done"}, done_n, 1);
        chk({tag, " req_cycles"}, req_n, exp_rej ? 0 : ack_dly);
        chk({tag, " bpm_valid"}, val_n, exp_rej ? 0 : 1);
        chk({tag, " early_arm"}, early, 0);
        chk({tag, " bpm_out"}, bpm_out, m_bpm);
        chk({tag, " no_signal"}, no_signal, m_ns);
        if (!exp_rej) begin
            chk({tag, " req_latency"}, req_lat, 2);
            chk({tag, " div_interval"}, bad_int, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tick_25hz = 1'b0; ti_valid = 1'b0;
        ti_count = '0; div_ack = 1'b0; div_bpm = '0;
        step(); step();
        chk("reset outputs", {ti_en, ti_done, div_req, div_interval, bpm_out, bpm_valid,
                              reject, no_signal, busy}, 0);
        rst = 1'b0;
        step();
        chk("idle busy", busy, 0);
        start = 1'b1;
        step();
        chk("arm ti_en", ti_en, 1);
        chk("arm busy", busy, 1);

        run_interval(25, 8'd99, 1, 1'b0, "stale");
        run_interval(25, 8'd60, 3, 1'b0, "normal");
        run_interval(5, 8'd11, 1, 1'b0, "short");
        run_interval(62, 8'd12, 1, 1'b0, "long");
        run_interval(7, 8'd13, 1, 1'b0, "min-1");
        run_interval(61, 8'd14, 1, 1'b0, "max+1");
        run_interval(8, 8'($urandom), 2, 1'b0, "min");
        run_interval(60, 8'($urandom), 1, 1'b0, "max");
        for (int k = 0; k < 10; k++)
            run_interval($urandom_range(0, 63), 8'($urandom), $urandom_range(1, 4), 1'b0, "rand");

        for (int i = 1; i <= 75; i++) begin
            tick_25hz = 1'b1;
            step();
            tick_25hz = 1'b0;
            if (i == 74) chk("no_signal before timeout", no_signal, 0);
            repeat ($urandom_range(0, 2)) step();
        end
        chk("no_signal at timeout", no_signal, 1);
        chk("ti_en after timeout", ti_en, 1);
        m_ns = 1'b1;
        m_discard = 1'b1;
        run_interval(25, 8'd50, 1, 1'b0, "post-timeout");
        run_interval(25, 8'd72, 2, 1'b0, "recover");

        run_interval(25, 8'd90, 10, 1'b1, "stop-div");
        chk("stop-div busy", busy, 0);
        repeat (3) step();
        chk("start+stop busy", busy, 0);
        chk("start+stop ti_en", ti_en, 0);
        stop = 1'b0;
        step();
        chk("rearm ti_en", ti_en, 1);
        m_discard = 1'b1;
        run_interval(30, 8'd40, 1, 1'b0, "rearm-stale");

        ti_count = 6'd30;
        ti_valid = 1'b1;
        step();
        chk("check busy", busy, 1);
        chk("check ti_en", ti_en, 0);
        stop = 1'b1;
        step();
        chk("stop-check reject", reject, 0);
        chk("stop-check ti_done", ti_done, 1);
        chk("stop-check div_req", div_req, 0);
        step();
        chk("release holds", busy, 1);
        chk("ti_done one cycle", ti_done, 0);
        ti_valid = 1'b0;
        step();
        chk("stop-check idle", busy, 0);
        stop = 1'b0;
        step();
        chk("restart ti_en", ti_en, 1);
        m_discard = 1'b1;
        m_first = 1'b1;

        stop = 1'b1;
        step();
        chk("stop-arm idle", busy, 0);
        stop = 1'b0;
        step();
        chk("stop-arm rearm", ti_en, 1);
        run_interval(20, 8'd33, 1, 1'b0, "final-stale");
        run_interval(40, 8'($urandom), 2, 1'b0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bpm_measure_ctrl.md
Name: bpm_measure_ctrl

Overview:
- Sequencer between the beat-interval counter and the BPM divider.
- Arms the counter and range-checks each finished interval.
- Hands valid intervals to the divider with a req/ack handshake, then releases the counter via its calc-done input.
- Publishes the BPM result and raises a no-signal flag when no interval completes within a timeout.

Parameters:
- MIN_TICKS, 8: smallest accepted interval in 25 Hz ticks (187 BPM ceiling).
- MAX_TICKS, 60: largest accepted interval (25 BPM floor).
- TIMEOUT_TICKS, 75: 25 Hz ticks spent in ARM before no_signal is set (3 s).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  level; begin or continue measuring
- stop  in  1  level; return to idle; wins over start
- tick_25hz  in  1  one-cycle 25 Hz strobe
- ti_valid  in  1  counter interval-ready (level; held until released)
- ti_count  in  6  counter interval value in ticks
- ti_en  out  1  counter enable
- ti_done  out  1  one-cycle release pulse to counter (calc-done)
- div_req  out  1  divider request
- div_interval  out  6  interval to divide; stable while div_req=1
- div_ack  in  1  one-cycle divider done; div_bpm valid that cycle
- div_bpm  in  8  divider result
- bpm_out  out  8  latest published BPM
- bpm_valid  out  1  one-cycle pulse when bpm_out updates
- reject  out  1  one-cycle pulse when an interval is discarded
- no_signal  out  1  sticky timeout flag
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: every output 0; state IDLE; discard flag 1; timeout counter 0.
- All outputs are registered.
- IDLE: ti_en=0. Go to ARM when start=1 and stop=0. Set the discard flag on this transition, because the counter may hold a stale partial count.
- ARM: ti_en=1.
  - Each tick_25hz increments a saturating 7-bit timeout counter.
  - When the count reaches TIMEOUT_TICKS, set no_signal=1 and the discard flag.
  - ti_valid=1 goes to CHECK and clears the timeout counter.
- CHECK (1 cycle): reject the interval if the discard flag is set, or if ti_count < MIN_TICKS, or if ti_count > MAX_TICKS.
  - On reject: pulse reject, clear the discard flag, go to RELEASE.
  - Otherwise: latch ti_count into div_interval, assert div_req, go to DIV.
- DIV: hold div_req=1 and div_interval until div_ack.
  - On div_ack: drop div_req the next cycle, load bpm_out=div_bpm, pulse bpm_valid, clear no_signal, go to RELEASE.
  - The divider is never abandoned: stop has no effect in DIV until ack.
- RELEASE: pulse ti_done for exactly one cycle on entry, then wait for ti_valid=0. The counter's valid stays high one cycle after calc-done.
  - If stop=1 or start=0, go to IDLE; otherwise go to ARM.
- stop=1 in ARM or CHECK goes to IDLE next cycle.
  - From CHECK, stop pulses ti_done first: path CHECK->RELEASE->IDLE, with no reject pulse.
- Timeout behaviour in ARM: ti_en stays 1. The counter may wrap, so the first interval after a timeout is always discarded.
- Latency: ti_valid rise to div_req is 2 cycles; div_ack to bpm_valid is 1 cycle (2 with AVG_EN).
- ti_valid and tick_25hz in the same cycle: the tick is counted, then ARM exits.

Optional Feature:
- Macro BPM_MEASURE_CTRL_AVG_EN.
- Defined:
  - bpm_out is the 4-entry moving average of accepted div_bpm values: 10-bit sum, >>2, truncated.
  - The first accepted result after reset or after IDLE preloads all four entries.
  - bpm_valid is delayed one extra cycle.
- Undefined: bpm_out = div_bpm directly. No window registers exist.

Decomposition:
- Package bpm_ctrl_pkg holds:
  - the state encoding (IDLE, ARM, CHECK, DIV, RELEASE, 3 bits);
  - the default tick constants (MIN/MAX/TIMEOUT);
  - widths: interval 6, bpm 8, timeout counter 7.
- One sub-module, bpm_avg4: window registers, sum and valid delay. Instantiated only under the macro.

Test Plan:
- Discarded first interval: start, ti_count=25 -> reject pulse, ti_done pulse, no div_req.
- Normal interval: a second interval of 25, div_ack with div_bpm=60 -> div_interval=25, bpm_out=60, one bpm_valid pulse, ti_done one cycle; ARM resumes only after ti_valid falls.
- Range check: ti_count=5 and ti_count=62 -> reject each, no div_req, bpm_out unchanged.
- Timeout: 75 tick_25hz pulses with no ti_valid -> no_signal=1. The next interval is rejected. The following good one with div_bpm=72 clears no_signal.
- Stop during DIV with div_ack 10 cycles later -> div_req held for those 10 cycles, bpm_out updates, ti_done pulses, then IDLE with busy=0. start+stop together in IDLE -> stays IDLE.
- AVG_EN: accepted results 60,64,68,72 -> bpm_out 60,61,63,66.
